// File: rtl/module_keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : module_keypad_scan_if
// Brief    : Keypad pins plus debounced key-event outputs of the scanner.
// Revision : 1.0
// ============================================================================
interface module_keypad_scan_if;
    logic [3:0] row;
    logic [3:0] column;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        input  row,
        output column,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output row,
        input  column,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface
`default_nettype wire

// File: rtl/module_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : module_keypad_scan
// Brief    : 4x4 keypad column scanner with debounce; one strobe per press.
// Revision : 1.0
// ============================================================================
module module_keypad_scan #(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    module_keypad_scan_if.master kp_if
);

    localparam int c_SCAN_W = $clog2(SCAN_CYCLES);
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [c_SCAN_W-1:0] c_SETTLE    = c_SCAN_W'(2);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [3:0]          sync1_q;
    logic [3:0]          rs_q;
    logic [c_SCAN_W-1:0] scan_cnt_q;
    logic [c_DB_W-1:0]   db_cnt_q;
    logic [1:0]          row_idx_q;
    logic [1:0]          col_idx_q;
    logic [3:0]          column_q;
    logic                key_valid_q;
    logic [3:0]          key_code_q;
    logic                key_held_q;

    logic [1:0]          w_row_idx;
    logic [1:0]          w_col_idx;
    logic                w_row_bit;
    logic [3:0]          w_col_rot;

    function automatic logic [3:0] f_key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest active (low) row index wins when several rows read low.
    always_comb begin
        w_row_idx = 2'd3;
        if (!rs_q[2]) w_row_idx = 2'd2;
        if (!rs_q[1]) w_row_idx = 2'd1;
        if (!rs_q[0]) w_row_idx = 2'd0;
    end

    always_comb begin
        w_col_idx = 2'd3;
        if (!column_q[2]) w_col_idx = 2'd2;
        if (!column_q[1]) w_col_idx = 2'd1;
        if (!column_q[0]) w_col_idx = 2'd0;
    end

    assign w_row_bit = rs_q[row_idx_q];
    assign w_col_rot = {column_q[2:0], column_q[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
            scan_cnt_q  <= '0;
            db_cnt_q    <= '0;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            column_q    <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= kp_if.row;
            rs_q        <= sync1_q;
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    // First two counts after a column change still carry the old column's rows.
                    if ((scan_cnt_q >= c_SETTLE) && (rs_q != 4'hF)) begin
                        row_idx_q <= w_row_idx;
                        col_idx_q <= w_col_idx;
                        db_cnt_q  <= '0;
                        state_q   <= ST_DEBOUNCE;
                    end else if (scan_cnt_q == c_SCAN_LAST) begin
                        column_q   <= w_col_rot;
                        scan_cnt_q <= '0;
                    end else begin
                        scan_cnt_q <= scan_cnt_q + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_row_bit) begin
                        column_q   <= w_col_rot;
                        scan_cnt_q <= '0;
                        state_q    <= ST_SCAN;
                    end else if (db_cnt_q == c_DB_LAST) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= f_key_map(row_idx_q, col_idx_q);
                        key_held_q  <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_row_bit) begin
                        db_cnt_q   <= '0;
                        key_held_q <= 1'b0;
                        state_q    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_row_bit) begin
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == c_DB_LAST) begin
                        column_q   <= w_col_rot;
                        scan_cnt_q <= '0;
                        state_q    <= ST_SCAN;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign kp_if.column    = column_q;
    assign kp_if.key_valid = key_valid_q;
    assign kp_if.key_code  = key_code_q;
    assign kp_if.key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_module_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_module_keypad_scan
// Brief    : Directed keypad-model bench for module_keypad_scan.
// Revision : 1.0
// ============================================================================
module tb_module_keypad_scan;

    localparam int c_SCAN = 8;
    localparam int c_DB   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;   // bit row*4+col set = key pressed

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    module_keypad_scan_if kif ();

    module_keypad_scan #(
        .SCAN_CYCLES     (c_SCAN),
        .DEBOUNCE_CYCLES (c_DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .kp_if (kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        kif.row = 4'hF;
        for (int i = 0; i < 4; i++)
            kif.row[i] = ~|(keys[i*4 +: 4] & ~kif.column);
    end

    typedef struct {
        string       name;
        logic [15:0] mask;
        int          hold;
        logic [3:0]  code;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
        if (kif.key_valid) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_kv(input string name, input int bound, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (n < bound && !found) begin
            tick();
            n++;
            if (kif.key_valid) found = 1'b1;
        end
        check({name, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_column"}, 32'(kif.column), 32'hE);
        check({name, "_valid"}, 32'(kif.key_valid), 32'd0);
        check({name, "_code"}, 32'(kif.key_code), 32'h0);
        check({name, "_held"}, 32'(kif.key_held), 32'd0);
    endtask

    initial begin
        int n;
        int p0;
        bit changed;
        logic [3:0] col0;

        vecs[0] = '{name: "key_2",    mask: 16'h0002, hold: 20, code: 4'h2};
        vecs[1] = '{name: "key_star", mask: 16'h1000, hold: 20, code: 4'hE};
        vecs[2] = '{name: "key_hash", mask: 16'h4000, hold: 20, code: 4'hF};
        vecs[3] = '{name: "key_D",    mask: 16'h8000, hold: 20, code: 4'hD};
        vecs[4] = '{name: "key_4_7",  mask: 16'h0110, hold: 20, code: 4'h4};

        // Reset values and free-running column rotation.
        rst = 1'b1;
        ticks(10);
        check_reset_outputs("reset");
        rst = 1'b0;
        ticks(7);
        check("col_before_step", 32'(kif.column), 32'hE);
        tick();
        check("col_step1", 32'(kif.column), 32'hD);
        ticks(c_SCAN);
        check("col_step2", 32'(kif.column), 32'hB);
        ticks(c_SCAN);
        check("col_step3", 32'(kif.column), 32'h7);
        ticks(c_SCAN);
        check("col_wrap", 32'(kif.column), 32'hE);

        // Key "1" pressed right at reset release: exact latency.
        rst = 1'b1;
        ticks(3);
        p0 = pulses;
        rst = 1'b0;
        keys = 16'h0001;
        wait_kv("key_1", 200, n);
        check("key_1_latency", 32'(n), 32'(c_DB + 3));
        check("key_1_code", 32'(kif.key_code), 32'h1);
        check("key_1_held", 32'(kif.key_held), 32'd1);
        tick();
        check("key_1_strobe_width", 32'(kif.key_valid), 32'd0);
        ticks(20);
        check("key_1_one_pulse", 32'(pulses - p0), 32'd1);
        keys = 16'h0;
        ticks(2);
        check("key_1_held_2", 32'(kif.key_held), 32'd1);
        tick();
        check("key_1_held_fall", 32'(kif.key_held), 32'd0);

        // Table-driven presses across columns, special keys and row priority.
        for (int v = 0; v < 5; v++) begin
            ticks(40);
            p0 = pulses;
            keys = vecs[v].mask;
            wait_kv(vecs[v].name, 300, n);
            check({vecs[v].name, "_code"}, 32'(kif.key_code), 32'(vecs[v].code));
            ticks(vecs[v].hold);
            check({vecs[v].name, "_held"}, 32'(kif.key_held), 32'd1);
            keys = 16'h0;
            ticks(2);
            check({vecs[v].name, "_held_2"}, 32'(kif.key_held), 32'd1);
            tick();
            check({vecs[v].name, "_held_fall"}, 32'(kif.key_held), 32'd0);
            ticks(30);
            check({vecs[v].name, "_pulses"}, 32'(pulses - p0), 32'd1);
        end

        // Bouncing "5" must never strobe; scanning must resume.
        ticks(40);
        p0 = pulses;
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            ticks(5);
        end
        keys = 16'h0;
        ticks(30);
        col0 = kif.column;
        changed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (kif.column != col0) changed = 1'b1;
        end
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        check("bounce_scan_resumes", 32'(changed), 32'd1);
        keys = 16'h0020;
        wait_kv("key_5", 300, n);
        check("key_5_code", 32'(kif.key_code), 32'h5);
        keys = 16'h0;
        ticks(40);
        check("key_5_pulses", 32'(pulses - p0), 32'd1);

        // Long hold of "A" plus a short glitch during release.
        p0 = pulses;
        keys = 16'h0008;
        wait_kv("key_A", 300, n);
        check("key_A_code", 32'(kif.key_code), 32'hA);
        ticks(300);
        check("key_A_long_hold_pulses", 32'(pulses - p0), 32'd1);
        check("key_A_long_hold_held", 32'(kif.key_held), 32'd1);
        keys = 16'h0;
        n = 0;
        while (kif.key_held && n < 10) begin
            tick();
            n++;
        end
        check("key_A_release_held", 32'(kif.key_held), 32'd0);
        ticks(5);
        keys = 16'h0008;
        ticks(4);
        check("key_A_glitch_held", 32'(kif.key_held), 32'd0);
        keys = 16'h0;
        ticks(80);
        check("key_A_glitch_pulses", 32'(pulses - p0), 32'd1);
        check("key_A_glitch_held_end", 32'(kif.key_held), 32'd0);

        // Reset eight cycles into debounce drops the strobe; held key re-detected.
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        keys = 16'h0001;
        ticks(3 + 8);
        p0 = pulses;
        rst = 1'b1;
        ticks(10);
        check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
        check_reset_outputs("midrst");
        rst = 1'b0;
        wait_kv("midrst_redetect", 200, n);
        check("midrst_latency", 32'(n), 32'(c_DB + 3));
        check("midrst_code", 32'(kif.key_code), 32'h1);
        keys = 16'h0;
        ticks(30);
        check("midrst_pulses", 32'(pulses - p0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/module_keypad_scan.md
# module_keypad_scan

Input stage of the keypad calculator. It scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines. It synchronises and debounces the press, then emits a one-cycle `key_valid` strobe with a 4-bit key code. Downstream, the operand/operator entry logic inside `module_top_general` consumes the strobe. The block replaces direct use of raw `row`/`column` pins by that logic.

## Interface
- `SCAN_CYCLES`, default 50000: clock cycles each column stays active while scanning; must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- `clk`  in  1  system clock, 100 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad row lines, asynchronous, active-low (pulled up; 0 = key in active column pressed).
- `column`  out  4  column drive, one-cold; bit j low = column j active.
- `key_valid`  out  1  one-cycle strobe: debounced new press.
- `key_code`  out  4  code of the last accepted key; holds until the next strobe.
- `key_held`  out  1  high while the accepted key is still pressed (HOLD state).

## Operation
- Row input passes a 2-FF synchroniser; both stages reset to 4'hF. `rs` denotes the synchronised value.
- Key map, row i / column j (index = bit position) → code:
  - Row 0: 1, 2, 3, A → 0x1, 0x2, 0x3, 0xA
  - Row 1: 4, 5, 6, B → 0x4, 0x5, 0x6, 0xB
  - Row 2: 7, 8, 9, C → 0x7, 0x8, 0x9, 0xC
  - Row 3: *, 0, #, D → 0xE, 0x0, 0xF, 0xD
- Multiple rows low at once: the lowest row index wins. Only that row bit is tracked afterwards.
- State machine, 2-bit state, reset to SCAN:
  - **SCAN**
    - `scan_cnt` counts 0..SCAN_CYCLES-1. At terminal count, `column` rotates 1110→1101→1011→0111→1110 and `scan_cnt` clears.
    - Detection is ignored while `scan_cnt` < 2 (synchroniser settling after a column change).
    - When `scan_cnt` ≥ 2 and `rs` ≠ 4'hF: latch row index and column index, freeze `column`, clear `db_cnt`, go to DEBOUNCE.
  - **DEBOUNCE**
    - If the latched row bit in `rs` is 0, `db_cnt` increments.
    - When `db_cnt` == DEBOUNCE_CYCLES-1 with the bit still 0: register `key_valid`=1 and `key_code`=map(row, col) on the next edge, then go to HOLD.
    - If the bit reads 1 at any cycle: no strobe. Go to SCAN, advance `column` to the next column, clear `scan_cnt`.
  - **HOLD**
    - `key_held`=1, `column` frozen.
    - When the latched row bit reads 1: clear `db_cnt`, go to RELEASE.
  - **RELEASE**
    - `key_held`=0.
    - `db_cnt` counts while the latched row bit reads 1; the bit reading 0 clears `db_cnt`.
    - At `db_cnt` == DEBOUNCE_CYCLES-1: go to SCAN, advance to the next column, clear `scan_cnt`.
- Auto-repeat is not provided: one strobe per physical press, regardless of hold time.
- `rst` in any state, including mid-DEBOUNCE or mid-HOLD, aborts the operation; any pending strobe is dropped. A key still held after reset is re-detected and produces a new strobe after a full debounce.

## Timing
- Reset values: `column`=4'b1110, `key_valid`=0, `key_code`=4'h0, `key_held`=0, `scan_cnt`=0, `db_cnt`=0.
- All outputs are registered; no combinational path from `row` to any output.
- Row edge to `rs`: 2 cycles.
- `rs` showing the press in SCAN (`scan_cnt` ≥ 2) → state = DEBOUNCE after 1 edge.
- DEBOUNCE entry to `key_valid` high: exactly DEBOUNCE_CYCLES cycles.
- Total latency from a stable row input (column already active, past settle) to `key_valid`: DEBOUNCE_CYCLES+3 edges.
- `key_valid` lasts exactly 1 cycle. `key_code` updates on the same edge and is stable from then on.
- `key_held` rises on the same edge as `key_valid`. It falls 3 edges after the row line returns high.
- Minimum interval between two strobes: 2·DEBOUNCE_CYCLES+5 cycles.

## Test plan
Bench parameters: SCAN_CYCLES=8, DEBOUNCE_CYCLES=16. The keypad model drives `row[i]` = 0 iff a pressed key sits in row i and its column bit is 0 in `column`.

1. **Reset:** hold `rst` for 10 cycles → `column`=1110, `key_valid`=0, `key_code`=0, `key_held`=0. Release → `column` steps to 1101 after 8 cycles and wraps 0111→1110.
2. **Single press:** press key "1" (r0, c0) → exactly one `key_valid` pulse, 19 edges after the row falls, with `key_code`=0x1. `key_held`=1 until release plus 3 cycles. Then press "2" (r0, c1) → code 0x2.
3. **Bounce rejection:** toggle key "5" every 5 cycles for 60 cycles, then release → no `key_valid` and scanning continues. Then hold "5" steady → one pulse, code 0x5.
4. **Long hold:** hold "A" (r0, c3) for 300 cycles → one pulse, code 0xA. A release glitch shorter than 16 cycles during RELEASE → no second pulse.
5. **Special keys and priority:** "*" → 0xE, "#" → 0xF, "D" → 0xD. "4" and "7" pressed together → 0x4.
6. **Reset mid-operation:** assert `rst` 8 cycles into DEBOUNCE → no pulse, outputs at reset values. Keep the key held → a new pulse after the full debounce, correct code.
